// File: rtl/vga_cell_arbiter.sv
// Single-port board RAM arbiter between the VGA pixel reader and the PicoBlaze port interface.
// Optional ARB_STATS_EN adds saturating miss/stall statistics counters.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// C_IDLE    | no CPU transaction in flight; CPU may compete for the port
// C_RD_WAIT | read issued to RAM, waiting for synchronous read data
// C_DONE    | access complete; ack (and read capture) registered on exit
module vga_cell_arbiter #(
   parameter int                ADDR_W       = 8,
   parameter int                DATA_W       = 8,
   parameter int                STARVE_LIMIT = 15,
   parameter logic [DATA_W-1:0] BG_COLOR     = '0
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_video_on,
   input  logic              i_vga_req,
   input  logic [ADDR_W-1:0] i_vga_addr,
   output logic              o_vga_valid,
   output logic              o_vga_miss,
   output logic [DATA_W-1:0] o_vga_data,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_ack,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_we,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
`ifdef ARB_STATS_EN
  ,output logic [15:0]       o_stat_miss,
   output logic [15:0]       o_stat_stall
`endif
);

   typedef enum logic [1:0] {
      C_IDLE    = 2'd0,
      C_RD_WAIT = 2'd1,
      C_DONE    = 2'd2
   } cpu_state_t;

   localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);

   cpu_state_t        r_state;
   cpu_state_t        w_state_nxt;

   logic [7:0]        r_starve;
   logic              r_cpu_is_rd;
   logic              r_cpu_ack;
   logic [DATA_W-1:0] r_cpu_rdata;

   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_we;
   logic [DATA_W-1:0] r_mem_wdata;

   logic              r_vga_hit1;
   logic              r_vga_miss1;
   logic              r_vga_hit2;
   logic              r_vga_miss2;
   logic              r_vga_valid;
   logic              r_vga_miss;
   logic [DATA_W-1:0] r_vga_data;

   logic              w_cpu_pend;
   logic              w_cpu_win;
   logic              w_vga_win;
   logic              w_vga_drop;
   logic              w_ack_nxt;
   logic              w_rd_capture;

   // The ack cycle is excluded so a requester still holding cpu_req is not re-granted.
   assign w_cpu_pend = i_cpu_req && (r_state == C_IDLE) && !r_cpu_ack;
   assign w_cpu_win  = w_cpu_pend &&
                       (!i_vga_req || !i_video_on || (r_starve == LP_LIMIT));
   assign w_vga_win  = i_vga_req && !w_cpu_win;
   assign w_vga_drop = i_vga_req && w_cpu_win;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= C_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_ack_nxt    = 1'b0;
      w_rd_capture = 1'b0;
      case (r_state)
         C_IDLE: begin
            if (w_cpu_win) begin
               w_state_nxt = i_cpu_we ? C_DONE : C_RD_WAIT;
            end
         end
         C_RD_WAIT: begin
            w_state_nxt = C_DONE;
         end
         C_DONE: begin
            w_state_nxt  = C_IDLE;
            w_ack_nxt    = 1'b1;
            w_rd_capture = r_cpu_is_rd;
         end
         default: begin
            w_state_nxt = C_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_starve    <= '0;
         r_cpu_is_rd <= 1'b0;
         r_cpu_ack   <= 1'b0;
         r_cpu_rdata <= '0;
      end else begin
         if (w_cpu_pend && !w_cpu_win) begin
            if (r_starve != 8'hFF) begin
               r_starve <= r_starve + 8'd1;
            end
         end else begin
            r_starve <= '0;
         end
         if (w_cpu_win) begin
            r_cpu_is_rd <= !i_cpu_we;
         end
         r_cpu_ack <= w_ack_nxt;
         // Read data left RAM one edge ago; it is still on the bus even if VGA now owns the port.
         if (w_rd_capture) begin
            r_cpu_rdata <= i_mem_rdata;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
      end else begin
         if (w_cpu_win) begin
            r_mem_addr  <= i_cpu_addr;
            r_mem_we    <= i_cpu_we;
            r_mem_wdata <= i_cpu_wdata;
         end else begin
            r_mem_we <= 1'b0;
            if (w_vga_win) begin
               r_mem_addr <= i_vga_addr;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_vga_hit1  <= 1'b0;
         r_vga_miss1 <= 1'b0;
         r_vga_hit2  <= 1'b0;
         r_vga_miss2 <= 1'b0;
         r_vga_valid <= 1'b0;
         r_vga_miss  <= 1'b0;
         r_vga_data  <= '0;
      end else begin
         r_vga_hit1  <= w_vga_win;
         r_vga_miss1 <= w_vga_drop;
         r_vga_hit2  <= r_vga_hit1;
         r_vga_miss2 <= r_vga_miss1;
         r_vga_valid <= r_vga_hit2;
         r_vga_miss  <= r_vga_miss2;
         if (r_vga_hit2) begin
            r_vga_data <= i_mem_rdata;
         end else if (r_vga_miss2) begin
            r_vga_data <= BG_COLOR;
         end
      end
   end

   assign o_vga_valid = r_vga_valid;
   assign o_vga_miss  = r_vga_miss;
   assign o_vga_data  = r_vga_data;
   assign o_cpu_ack   = r_cpu_ack;
   assign o_cpu_rdata = r_cpu_rdata;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_we    = r_mem_we;
   assign o_mem_wdata = r_mem_wdata;

`ifdef ARB_STATS_EN
   logic        r_video_d;
   logic [15:0] r_stat_miss;
   logic [15:0] r_stat_stall;
   logic        w_stat_clr;

   assign w_stat_clr = i_video_on && !r_video_d;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_video_d    <= 1'b0;
         r_stat_miss  <= '0;
         r_stat_stall <= '0;
      end else begin
         r_video_d <= i_video_on;
         if (w_stat_clr) begin
            r_stat_miss  <= '0;
            r_stat_stall <= '0;
         end else begin
            if (r_vga_miss && (r_stat_miss != 16'hFFFF)) begin
               r_stat_miss <= r_stat_miss + 16'd1;
            end
            if ((r_starve != 8'd0) && (r_stat_stall != 16'hFFFF)) begin
               r_stat_stall <= r_stat_stall + 16'd1;
            end
         end
      end
   end

   assign o_stat_miss  = r_stat_miss;
   assign o_stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_vga_cell_arbiter.sv
// Scoreboard bench for vga_cell_arbiter with a behavioural synchronous board RAM.
// Build with ARB_STATS_EN defined to also exercise the statistics counters.
module tb_vga_cell_arbiter;

   localparam int LIM = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       video_on;
   logic       vga_req;
   logic [7:0] vga_addr;
   logic       vga_valid;
   logic       vga_miss;
   logic [7:0] vga_data;
   logic       cpu_req;
   logic       cpu_we;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       cpu_ack;
   logic [7:0] cpu_rdata;
   logic [7:0] mem_addr;
   logic       mem_we;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
`ifdef ARB_STATS_EN
   logic [15:0] stat_miss;
   logic [15:0] stat_stall;
`endif

   vga_cell_arbiter #(
      .ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(LIM), .BG_COLOR(8'h00)
   ) dut (
      .i_clk(clk), .i_reset(reset), .i_video_on(video_on),
      .i_vga_req(vga_req), .i_vga_addr(vga_addr),
      .o_vga_valid(vga_valid), .o_vga_miss(vga_miss), .o_vga_data(vga_data),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
      .i_cpu_wdata(cpu_wdata), .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
      .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
     ,.o_stat_miss(stat_miss), .o_stat_stall(stat_stall)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] ram_init(input logic [7:0] a);
      if (a == 8'h20) return 8'h1C;
      if (a == 8'h10) return 8'h3F;
      return a ^ 8'h5A;
   endfunction

   // Board RAM: synchronous read, old data returned on a same-address write.
   logic [7:0] ram [256];
   initial begin
      for (int i = 0; i < 256; i++) ram[i] <= ram_init(8'(i));
   end
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
   endtask

   typedef struct { logic miss; logic [7:0] data; int cyc; } vga_exp_t;
   typedef struct { logic rd;   logic [7:0] data; int cyc; } cpu_exp_t;
   typedef struct { logic [7:0] addr; logic [7:0] data; int cyc; } wr_exp_t;

   vga_exp_t q_vga[$];
   cpu_exp_t q_cpu[$];
   wr_exp_t  q_wr[$];

   vga_exp_t m_ve;
   cpu_exp_t m_ce;
   wr_exp_t  m_we;

   always @(negedge clk) begin
      if (vga_valid || vga_miss) begin
         if (q_vga.size() == 0) begin
            check_eq("vga_unexpected", 1, 0);
         end else begin
            m_ve = q_vga.pop_front();
            check_eq("vga_both", 32'(vga_valid & vga_miss), 0);
            check_eq("vga_kind", 32'(vga_miss), 32'(m_ve.miss));
            check_eq("vga_data", 32'(vga_data), 32'(m_ve.data));
            check_eq("vga_cycle", cyc, m_ve.cyc);
         end
      end
      if (cpu_ack) begin
         if (q_cpu.size() == 0) begin
            check_eq("ack_unexpected", 1, 0);
         end else begin
            m_ce = q_cpu.pop_front();
            check_eq("ack_cycle", cyc, m_ce.cyc);
            if (m_ce.rd) check_eq("cpu_rdata", 32'(cpu_rdata), 32'(m_ce.data));
         end
      end
      if (mem_we) begin
         if (q_wr.size() == 0) begin
            check_eq("mem_we_unexpected", 1, 0);
         end else begin
            m_we = q_wr.pop_front();
            check_eq("mem_addr", 32'(mem_addr), 32'(m_we.addr));
            check_eq("mem_wdata", 32'(mem_wdata), 32'(m_we.data));
            check_eq("mem_we_cycle", cyc, m_we.cyc);
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic wait_ack();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 16 && !got; i++) begin
         @(negedge clk);
         got = cpu_ack;
      end
      check_eq("ack_seen", 32'(got), 1);
      cpu_req = 1'b0;
   endtask

   task automatic vga_strobe(input logic [7:0] a, input logic [7:0] exp_data);
      vga_req  = 1'b1;
      vga_addr = a;
      q_vga.push_back('{miss: 1'b0, data: exp_data, cyc: cyc + 3});
      @(negedge clk);
      vga_req = 1'b0;
   endtask

   // Continuous VGA stream with a CPU read of 0x10 raised on the first strobe.
   task automatic starve_run();
      int c0;
      logic [7:0] a;
      c0 = cyc;
      for (int i = 0; i < 10; i++) begin
         a        = 8'h20 + 8'(i % 4);
         vga_req  = 1'b1;
         vga_addr = a;
         if (i == LIM) q_vga.push_back('{miss: 1'b1, data: 8'h00, cyc: c0 + i + 3});
         else          q_vga.push_back('{miss: 1'b0, data: ram_init(a), cyc: c0 + i + 3});
         if (i == 0) begin
            cpu_req  = 1'b1;
            cpu_we   = 1'b0;
            cpu_addr = 8'h10;
            q_cpu.push_back('{rd: 1'b1, data: 8'h3F, cyc: c0 + LIM + 3});
         end
         @(negedge clk);
         if (cpu_ack) cpu_req = 1'b0;
      end
      vga_req = 1'b0;
      if (cpu_req) wait_ack();
      idle(4);
   endtask

   initial begin
      int c0;
      reset = 1'b1; video_on = 1'b0;
      vga_req = 1'b0; vga_addr = 8'h00;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;

      // Reset dominates active requests
      vga_req = 1'b1; vga_addr = 8'h20;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h05; cpu_wdata = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rst_vga", {vga_valid, vga_miss, vga_data}, 0);
         check_eq("rst_cpu", {cpu_ack, cpu_rdata}, 0);
         check_eq("rst_mem", {mem_we, mem_addr, mem_wdata}, 0);
      end
      reset = 1'b0; vga_req = 1'b0; cpu_req = 1'b0;
      idle(3);

      // Single read latency, then 4 back-to-back strobes
      video_on = 1'b1;
      vga_strobe(8'h20, 8'h1C);
      idle(3);
      c0 = cyc;
      for (int i = 0; i < 4; i++) begin
         vga_req  = 1'b1;
         vga_addr = 8'h20 + 8'(i);
         q_vga.push_back('{miss: 1'b0, data: ram_init(8'h20 + 8'(i)), cyc: c0 + i + 3});
         @(negedge clk);
      end
      vga_req = 1'b0;
      idle(4);

      // Blanking: CPU write beats a simultaneous VGA strobe
      video_on = 1'b0;
      @(negedge clk);
      c0 = cyc;
      vga_req = 1'b1; vga_addr = 8'h21;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h05; cpu_wdata = 8'hE0;
      q_vga.push_back('{miss: 1'b1, data: 8'h00, cyc: c0 + 3});
      q_wr.push_back('{addr: 8'h05, data: 8'hE0, cyc: c0 + 1});
      q_cpu.push_back('{rd: 1'b0, data: 8'h00, cyc: c0 + 2});
      @(negedge clk);
      vga_req = 1'b0;
      wait_ack();
      idle(3);
      video_on = 1'b1;
      vga_strobe(8'h05, 8'hE0);
      idle(3);

      // Starvation limit forces a CPU grant during active video
      starve_run();

      // Reset while a CPU read sits in C_RD_WAIT abandons it
      video_on = 1'b0;
      @(negedge clk);
      check_eq("rdata_before_rst", 32'(cpu_rdata), 32'h3F);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h21;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; cpu_req = 1'b0;
      check_eq("rdata_after_rst", 32'(cpu_rdata), 0);
      idle(6);
      check_eq("rdata_still_0", 32'(cpu_rdata), 0);
      c0 = cyc;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h22;
      q_cpu.push_back('{rd: 1'b1, data: ram_init(8'h22), cyc: c0 + 3});
      wait_ack();
      idle(3);

`ifdef ARB_STATS_EN
      video_on = 1'b1;
      @(negedge clk);
      check_eq("stat_clr_miss", 32'(stat_miss), 0);
      for (int r = 0; r < 3; r++) starve_run();
      check_eq("stat_miss", 32'(stat_miss), 3);
      check_eq("stat_stall", 32'(stat_stall), 12);
      video_on = 1'b0;
      idle(2);
      video_on = 1'b1;
      @(negedge clk);
      check_eq("stat_miss_rise", 32'(stat_miss), 0);
      check_eq("stat_stall_rise", 32'(stat_stall), 0);
`endif

      idle(4);
      check_eq("vga_q_empty", q_vga.size(), 0);
      check_eq("cpu_q_empty", q_cpu.size(), 0);
      check_eq("wr_q_empty", q_wr.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "timeout");
   end

endmodule
